// File: rtl/exec_preproc_pipe.sv
// exec_preproc_pipe: execute-stage preprocessor for the DLX pipeline.
// Decodes control_in, stages ALU/shifter operands into a registered output
// slot with valid/ready handshakes, waits a bounded time for memory read data,
// and drives the data-memory write port.
// Optional build macro EXEC_PREPROC_STALL_CNT_EN adds a saturating 16-bit
// counter of upstream stall cycles on port stall_cnt.
module exec_preproc_pipe #(
    parameter int DATA_W      = 32,
    parameter int IMM_W       = 16,
    parameter int MEMWAIT_MAX = 15,
    localparam int SHAMT_W    = $clog2(DATA_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   src1,
    input  logic [DATA_W-1:0]   src2,
    input  logic [IMM_W-1:0]    imm,
    input  logic [6:0]          control_in,
    input  logic [DATA_W-1:0]   mem_rd_data,
    input  logic                mem_rd_valid,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   aluin1,
    output logic [DATA_W-1:0]   aluin2,
    output logic [2:0]          operation_out,
    output logic [2:0]          opselect_out,
    output logic [SHAMT_W-1:0]  shift_number,
    output logic                enable_arith,
    output logic                enable_shift,
    output logic                mem_wr_en,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic                mem_timeout
`ifdef EXEC_PREPROC_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam logic [2:0] SHIFT_REG   = 3'b000;
    localparam logic [2:0] ARITH_LOGIC = 3'b001;
    localparam logic [2:0] MEM_WRITE   = 3'b100;
    localparam logic [2:0] MEM_READ    = 3'b101;

    // Last wait-counter value: the wait expires when the counter would reach MEMWAIT_MAX.
    localparam logic [7:0] WCNT_LAST = 8'(MEMWAIT_MAX - 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t              state_q, state_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   aluin1_q, aluin1_d;
    logic [DATA_W-1:0]   aluin2_q, aluin2_d;
    logic [2:0]          op_q, op_d;
    logic [2:0]          sel_q, sel_d;
    logic [SHAMT_W-1:0]  shamt_q, shamt_d;
    logic                en_arith_q, en_arith_d;
    logic                en_shift_q, en_shift_d;
    logic                timeout_q, timeout_d;
    logic                accept;
    logic signed [DATA_W-1:0] immx;

    function automatic logic signed [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] v);
        logic signed [IMM_W-1:0] vs;
        vs = $signed(v);
        return DATA_W'(vs);
    endfunction

    assign immx     = sign_ext(imm);
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign mem_wr_en   = accept && (control_in[2:0] == MEM_WRITE) && control_in[3];
    assign mem_wr_data = src2;

    assign out_valid     = out_valid_q;
    assign aluin1        = aluin1_q;
    assign aluin2        = aluin2_q;
    assign operation_out = op_q;
    assign opselect_out  = sel_q;
    assign shift_number  = shamt_q;
    assign enable_arith  = en_arith_q;
    assign enable_shift  = en_shift_q;
    assign mem_timeout   = timeout_q;

    // Next-state decode: slot consume, accept/decode in IDLE, bounded memory wait.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        out_valid_d = out_valid_q;
        aluin1_d    = aluin1_q;
        aluin2_d    = aluin2_q;
        op_d        = op_q;
        sel_d       = sel_q;
        shamt_d     = shamt_q;
        en_arith_d  = en_arith_q;
        en_shift_d  = en_shift_q;
        timeout_d   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            en_arith_d  = 1'b0;
            en_shift_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    aluin1_d    = src1;
                    op_d        = control_in[6:4];
                    sel_d       = control_in[2:0];
                    shamt_d     = '0;
                    en_arith_d  = 1'b0;
                    en_shift_d  = 1'b0;
                    out_valid_d = 1'b1;
                    case (control_in[2:0])
                        ARITH_LOGIC: begin
                            aluin2_d   = control_in[3] ? immx : src2;
                            en_arith_d = 1'b1;
                        end
                        SHIFT_REG: begin
                            shamt_d    = imm[2] ? src2[SHAMT_W-1:0] : imm[6 +: SHAMT_W];
                            en_shift_d = 1'b1;
                        end
                        MEM_READ: begin
                            if (control_in[3]) begin
                                if (mem_rd_valid) begin
                                    aluin2_d   = mem_rd_data;
                                    en_arith_d = 1'b1;
                                end else begin
                                    state_d     = WAIT_MEM;
                                    wcnt_d      = '0;
                                    out_valid_d = 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_MEM: begin
                // Data arriving on the expiry cycle takes priority over the timeout.
                if (mem_rd_valid) begin
                    aluin2_d    = mem_rd_data;
                    en_arith_d  = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (wcnt_q == WCNT_LAST) begin
                    aluin2_d    = '0;
                    en_arith_d  = 1'b0;
                    out_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output-slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            aluin1_q    <= '0;
            aluin2_q    <= '0;
            op_q        <= '0;
            sel_q       <= '0;
            shamt_q     <= '0;
            en_arith_q  <= 1'b0;
            en_shift_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            aluin1_q    <= aluin1_d;
            aluin2_q    <= aluin2_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            shamt_q     <= shamt_d;
            en_arith_q  <= en_arith_d;
            en_shift_q  <= en_shift_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef EXEC_PREPROC_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    // Count cycles where upstream offers an op that cannot be taken; saturates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: doc/exec_preproc_pipe.md
Name: exec_preproc_pipe

Overview:
Parametrised execute-stage preprocessor for the DLX pipeline. It decodes control_in and stages ALU/shifter operands into a registered output slot with valid/ready handshakes on both sides. Memory-read operands wait, with a bounded wait, for read data. It sits between decode and the arith/shift units and drives the data-memory write port.

Parameters:
DATA_W, 32, operand/register width; power of two, >= 16
IMM_W, 16, immediate width; must be >= 6 + SHAMT_W
MEMWAIT_MAX, 15, max cycles in WAIT_MEM before timeout; 1..255
SHAMT_W (localparam), $clog2(DATA_W), shift amount width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept this cycle
src1  input  DATA_W  register operand 1
src2  input  DATA_W  register operand 2 / store data
imm  input  IMM_W  immediate
control_in  input  7  [6:4] operation, [3] imm/mem flag, [2:0] opselect
mem_rd_data  input  DATA_W  memory read data
mem_rd_valid  input  1  mem_rd_data valid this cycle
out_valid  output  1  output slot holds an operation
out_ready  input  1  downstream consumes the slot
aluin1  output  DATA_W  ALU operand 1
aluin2  output  DATA_W  ALU operand 2
operation_out  output  3  control_in[6:4] of the staged op
opselect_out  output  3  control_in[2:0] of the staged op
shift_number  output  SHAMT_W  shift amount
enable_arith  output  1  arith unit enable, qualified by out_valid
enable_shift  output  1  shift unit enable, qualified by out_valid
mem_wr_en  output  1  memory write strobe, combinational
mem_wr_data  output  DATA_W  = src2, combinational
mem_timeout  output  1  one-cycle pulse when the memory wait expires

Behaviour:
- Opselect codes: SHIFT_REG 3'b000, ARITH_LOGIC 3'b001, MEM_WRITE 3'b100, MEM_READ 3'b101.
- Reset (reset==0 at posedge): state IDLE; wait counter 0; every registered output 0 (out_valid, aluin1, aluin2, operation_out, opselect_out, shift_number, enable_arith, enable_shift, mem_timeout). Reset mid-WAIT_MEM abandons the op, and no output is produced for it.
- FSM states: IDLE, WAIT_MEM.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On the accept edge:
  - aluin1 <= src1
  - operation_out <= control_in[6:4]
  - opselect_out <= control_in[2:0]
- imm is sign-extended to DATA_W (immx).
- Decode on accept:
  - ARITH_LOGIC: aluin2 <= control_in[3] ? immx : src2; enable_arith 1; out_valid 1 next cycle.
  - SHIFT_REG: shift_number <= imm[2] ? src2[SHAMT_W-1:0] : imm[6+:SHAMT_W]; enable_shift 1; aluin2 holds; out_valid 1.
  - MEM_READ with control_in[3]=1:
    - If mem_rd_valid in the same cycle: aluin2 <= mem_rd_data; enable_arith 1; out_valid 1.
    - Otherwise go to WAIT_MEM with counter 0 and out_valid 0.
  - MEM_READ with control_in[3]=0: aluin2 holds; enable_arith 0; out_valid 1.
  - MEM_WRITE and all other codes: aluin2 holds; enables 0; out_valid 1.
  - shift_number is 0 for every non-SHIFT_REG op.
- WAIT_MEM:
  - Each cycle without mem_rd_valid, the counter increments.
  - On mem_rd_valid: aluin2 <= mem_rd_data; enable_arith 1; out_valid 1; go to IDLE.
  - Counter reaches MEMWAIT_MAX without data: aluin2 <= 0; enable_arith 0; out_valid 1; mem_timeout pulses 1 cycle; go to IDLE.
  - If mem_rd_valid arrives in the same cycle the counter reaches MEMWAIT_MAX, the data wins and there is no timeout.
- Output slot:
  - While out_valid && !out_ready, all outputs hold stable.
  - out_valid && out_ready with no new accept: out_valid 0; enable_arith and enable_shift 0; data outputs hold.
  - Consume and accept in the same cycle: the new op loads with no bubble.
- mem_wr_en = accept && control_in[2:0]==MEM_WRITE && control_in[3]. mem_wr_data = src2 at all times.
- Latency: 1 cycle from accept to out_valid; for a waiting MEM_READ, 1 cycle after the mem_rd_valid cycle.

Optional Feature:
EXEC_PREPROC_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0]. Increments each cycle in which (in_valid && !in_ready) holds, saturating at 16'hFFFF. Clears on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ARITH imm: control_in=7'b010_1_001, src1=5, imm=16'hFFFE, out_ready=1 -> next cycle out_valid=1, aluin1=5, aluin2=32'hFFFFFFFE, enable_arith=1, operation_out=3'b010.
- SHIFT: control_in=7'b000_0_000, imm bit2=0, imm[10:6]=7; then imm bit2=1, src2=32'h13 -> shift_number 7 then 19; enable_shift=1; aluin2 unchanged.
- MEM_READ wait: control_in=7'b000_1_101, mem_rd_valid low 3 cycles then data 32'hCAFE -> in_ready=0 throughout; out_valid on the cycle after the data; aluin2=32'hCAFE; enable_arith=1.
- Timeout: MEM_READ with mem_rd_valid never asserted, MEMWAIT_MAX=15 -> mem_timeout pulse after 15 wait cycles; aluin2=0; enable_arith=0; out_valid=1.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> back-to-back accept with no bubble. With the macro defined, stall_cnt=4.
- MEM_WRITE, then reset: control_in=7'b000_1_100, src2=32'h55 -> mem_wr_en=1 combinationally on the accept cycle, mem_wr_data=32'h55. A reset during a subsequent WAIT_MEM -> all outputs 0 next cycle, in_ready=1.
